instruction_fetch_unit: RTL and testbench

Producer side of the execution engine's instruction bundle interface. The unit fetches aligned 64-bit dual-issue bundles (two 32-bit instructions, low word issued first) from the instruction memory port. It buffers them in a prefetch FIFO and presents them on an `instr_valid`/`instr_ready` handshake. A redirect input (branch or warp switch) flushes the buffer and discards stale in-flight memory responses.

---
 rtl/instruction_fetch_unit.sv | 130 +++++++++++++
 tb/tb_instruction_fetch_unit.sv | 239 +++++++++++++++++++++++
 2 files changed

// File: rtl/instruction_fetch_unit.sv
// Instruction fetch front end: issues aligned 64-bit bundle requests to instruction memory,
// buffers responses in a prefetch FIFO and hands them to the execution engine.
module instruction_fetch_unit #(
  parameter int unsigned FIFO_DEPTH      = 4,
  parameter int unsigned MAX_OUTSTANDING = 4,
  parameter int unsigned PC_WIDTH        = 16,
  parameter int unsigned START_PC        = 0
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                fetch_enable,
  input  logic                redirect_valid,
  input  logic [PC_WIDTH-1:0] redirect_pc,
  output logic                imem_req,
  output logic [31:0]         imem_addr,
  input  logic                imem_gnt,
  input  logic                imem_rvalid,
  input  logic [63:0]         imem_rdata,
  output logic [63:0]         instruction_bundle,
  output logic                instr_valid,
  input  logic                instr_ready,
  output logic [PC_WIDTH-1:0] bundle_pc,
  output logic [31:0]         bundles_issued,
  output logic [15:0]         redirect_count
);

  localparam int unsigned PTR_W    = $clog2(FIFO_DEPTH);
  localparam int unsigned CNT_W    = $clog2(FIFO_DEPTH + 1);
  localparam int unsigned OUT_W    = $clog2(MAX_OUTSTANDING + 1);
  localparam int unsigned BUNDLE_W = 64;
  localparam int unsigned ADDR_W   = 32;

  logic [BUNDLE_W-1:0] fifo_mem [FIFO_DEPTH];
  logic [PTR_W-1:0]    wr_ptr_q, rd_ptr_q;
  logic [CNT_W-1:0]    fifo_count_q;
  logic [OUT_W-1:0]    outstanding_q, drop_cnt_q;
  logic [PC_WIDTH-1:0] fetch_pc_q;

  logic                gnt_fire, pop, push, credit_ok, req_nxt;
  logic [PTR_W-1:0]    wr_ptr_nxt, rd_ptr_nxt, rd_ptr_inc;
  logic [CNT_W-1:0]    fifo_count_nxt;
  logic [OUT_W-1:0]    outstanding_nxt, drop_cnt_nxt;
  logic [PC_WIDTH-1:0] fetch_pc_nxt, head_pc_nxt, redirect_target;
  logic [BUNDLE_W-1:0] bundle_nxt;

  // Next-state for credits, FIFO bookkeeping, PCs and the registered request/head outputs
  always_comb begin
    gnt_fire        = imem_req & imem_gnt;
    pop             = instr_valid & instr_ready;
    push            = imem_rvalid & (drop_cnt_q == '0) & ~redirect_valid;
    rd_ptr_inc      = rd_ptr_q + PTR_W'(1);
    redirect_target = redirect_pc & ~PC_WIDTH'(1);

    outstanding_nxt = outstanding_q + OUT_W'(gnt_fire) - OUT_W'(imem_rvalid);
    drop_cnt_nxt    = drop_cnt_q;
    fifo_count_nxt  = fifo_count_q + CNT_W'(push) - CNT_W'(pop);
    wr_ptr_nxt      = push ? wr_ptr_q + PTR_W'(1) : wr_ptr_q;
    rd_ptr_nxt      = pop ? rd_ptr_inc : rd_ptr_q;
    fetch_pc_nxt    = gnt_fire ? fetch_pc_q + PC_WIDTH'(2) : fetch_pc_q;
    head_pc_nxt     = pop ? bundle_pc + PC_WIDTH'(2) : bundle_pc;
    bundle_nxt      = instruction_bundle;

    if (imem_rvalid && (drop_cnt_q != '0)) begin
      drop_cnt_nxt = drop_cnt_q - OUT_W'(1);
    end

    if (redirect_valid) begin
      // Everything still in flight (including a grant this cycle) becomes stale
      drop_cnt_nxt   = outstanding_nxt;
      fifo_count_nxt = '0;
      wr_ptr_nxt     = '0;
      rd_ptr_nxt     = '0;
      fetch_pc_nxt   = redirect_target;
      head_pc_nxt    = redirect_target;
    end else if (pop && (fifo_count_q > CNT_W'(1))) begin
      bundle_nxt = fifo_mem[rd_ptr_inc];
    end else if (push && ((fifo_count_q == '0) || pop)) begin
      bundle_nxt = imem_rdata;
    end

    // Live responses plus buffered bundles plus the new request must fit the FIFO
    credit_ok = (32'(outstanding_nxt) + 32'd1 <= MAX_OUTSTANDING) &&
                (32'(outstanding_nxt) - 32'(drop_cnt_nxt) + 32'(fifo_count_nxt) + 32'd1
                 <= FIFO_DEPTH);
    req_nxt   = fetch_enable & credit_ok;
    if (imem_req && !imem_gnt && !redirect_valid) begin
      req_nxt = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      wr_ptr_q           <= '0;
      rd_ptr_q           <= '0;
      fifo_count_q       <= '0;
      outstanding_q      <= '0;
      drop_cnt_q         <= '0;
      fetch_pc_q         <= PC_WIDTH'(START_PC);
      imem_req           <= 1'b0;
      imem_addr          <= ADDR_W'({PC_WIDTH'(START_PC), 2'b00});
      instruction_bundle <= '0;
      instr_valid        <= 1'b0;
      bundle_pc          <= PC_WIDTH'(START_PC);
      bundles_issued     <= '0;
      redirect_count     <= '0;
    end else begin
      wr_ptr_q           <= wr_ptr_nxt;
      rd_ptr_q           <= rd_ptr_nxt;
      fifo_count_q       <= fifo_count_nxt;
      outstanding_q      <= outstanding_nxt;
      drop_cnt_q         <= drop_cnt_nxt;
      fetch_pc_q         <= fetch_pc_nxt;
      imem_req           <= req_nxt;
      imem_addr          <= ADDR_W'({fetch_pc_nxt, 2'b00});
      instruction_bundle <= bundle_nxt;
      instr_valid        <= (fifo_count_nxt != '0);
      bundle_pc          <= head_pc_nxt;
      bundles_issued     <= bundles_issued + 32'(pop);
      redirect_count     <= redirect_count + 16'(redirect_valid);
    end
  end

  // Prefetch storage; contents are only meaningful below fifo_count
  always_ff @(posedge clk) begin
    if (push) begin
      fifo_mem[wr_ptr_q] <= imem_rdata;
    end
  end

endmodule

// File: tb/tb_instruction_fetch_unit.sv
// Directed bench for instruction_fetch_unit with a fixed-latency in-order memory model
// that returns {~addr, addr} for each granted byte address.
module tb_instruction_fetch_unit;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        fetch_enable = 1'b0;
  logic        redirect_valid = 1'b0;
  logic [15:0] redirect_pc = '0;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_gnt = 1'b0;
  logic        imem_rvalid = 1'b0;
  logic [63:0] imem_rdata = '0;
  logic [63:0] instruction_bundle;
  logic        instr_valid;
  logic        instr_ready = 1'b0;
  logic [15:0] bundle_pc;
  logic [31:0] bundles_issued;
  logic [15:0] redirect_count;

  int unsigned n_checks = 0;
  int unsigned n_pass = 0;
  int unsigned cyc = 0;
  int unsigned lat = 2;
  int unsigned n_grants = 0;
  logic [31:0] q_addr [$];
  int unsigned q_due [$];
  logic        seen;

  always #5 clk = ~clk;

  instruction_fetch_unit #(
    .FIFO_DEPTH(4), .MAX_OUTSTANDING(4), .PC_WIDTH(16), .START_PC(0)
  ) dut (
    .clk(clk), .rst_n(rst_n), .fetch_enable(fetch_enable),
    .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
    .imem_req(imem_req), .imem_addr(imem_addr), .imem_gnt(imem_gnt),
    .imem_rvalid(imem_rvalid), .imem_rdata(imem_rdata),
    .instruction_bundle(instruction_bundle), .instr_valid(instr_valid),
    .instr_ready(instr_ready), .bundle_pc(bundle_pc),
    .bundles_issued(bundles_issued), .redirect_count(redirect_count)
  );

  // Memory model: record grants at the edge, present the response lat edges later
  always @(posedge clk) begin
    cyc = cyc + 1;
    if (!rst_n) begin
      q_addr.delete();
      q_due.delete();
    end else if (imem_req && imem_gnt) begin
      q_addr.push_back(imem_addr);
      q_due.push_back(cyc + lat);
      n_grants = n_grants + 1;
    end
  end

  always @(negedge clk) begin
    imem_rvalid = 1'b0;
    if (q_due.size() != 0 && q_due[0] == cyc + 1) begin
      imem_rvalid = 1'b1;
      imem_rdata  = {~q_addr[0], q_addr[0]};
      void'(q_due.pop_front());
      void'(q_addr.pop_front());
    end
  end

  function automatic logic [63:0] exp_data(input logic [15:0] pc);
    logic [31:0] a;
    a = {14'b0, pc, 2'b00};
    return {~a, a};
  endfunction

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset(input logic fe, input logic rdy, input logic gnt, input int unsigned l);
    rst_n = 1'b0;
    redirect_valid = 1'b0;
    redirect_pc = '0;
    fetch_enable = fe;
    instr_ready = rdy;
    imem_gnt = gnt;
    lat = l;
    tick();
    tick();
    n_grants = 0;
    rst_n = 1'b1;
  endtask

  initial begin
    // 1: reset state, streaming fetch at one bundle per cycle
    do_reset(1'b1, 1'b1, 1'b1, 2);
    check("rst_req", 64'(imem_req), 64'(0));
    check("rst_addr", 64'(imem_addr), 64'(0));
    check("rst_valid", 64'(instr_valid), 64'(0));
    check("rst_bundle", instruction_bundle, 64'(0));
    check("rst_pc", 64'(bundle_pc), 64'(0));
    check("rst_issued", 64'(bundles_issued), 64'(0));
    check("rst_redir", 64'(redirect_count), 64'(0));
    tick();
    check("t1_req", 64'(imem_req), 64'(1));
    check("t1_addr0", 64'(imem_addr), 64'h0);
    tick();
    check("t1_addr8", 64'(imem_addr), 64'h8);
    tick();
    check("t1_addr10", 64'(imem_addr), 64'h10);
    check("t1_not_yet_valid", 64'(instr_valid), 64'(0));
    tick();
    check("t1_valid", 64'(instr_valid), 64'(1));
    check("t1_pc0", 64'(bundle_pc), 64'h0);
    check("t1_data0", instruction_bundle, exp_data(16'h0));
    for (int k = 1; k <= 5; k++) begin
      tick();
      check("t1_pc", 64'(bundle_pc), 64'(2 * k));
      check("t1_data", instruction_bundle, exp_data(16'(2 * k)));
      check("t1_issued", 64'(bundles_issued), 64'(k));
    end

    // 2: consumer stalled, credit limit caps fetch at FIFO_DEPTH bundles
    do_reset(1'b1, 1'b0, 1'b1, 2);
    repeat (8) tick();
    check("t2_grants", 64'(n_grants), 64'(4));
    check("t2_req_off", 64'(imem_req), 64'(0));
    check("t2_valid", 64'(instr_valid), 64'(1));
    check("t2_hold_pc", 64'(bundle_pc), 64'h0);
    check("t2_hold_data", instruction_bundle, exp_data(16'h0));
    instr_ready = 1'b1;
    tick();
    check("t2_pc2", 64'(bundle_pc), 64'h2);
    check("t2_resume_req", 64'(imem_req), 64'(1));
    check("t2_resume_addr", 64'(imem_addr), 64'h20);
    tick();
    check("t2_pc4", 64'(bundle_pc), 64'h4);
    tick();
    check("t2_pc6", 64'(bundle_pc), 64'h6);
    tick();
    check("t2_pc8", 64'(bundle_pc), 64'h8);
    check("t2_data8", instruction_bundle, exp_data(16'h8));
    check("t2_valid8", 64'(instr_valid), 64'(1));

    // 3: request held stable without grant, even after fetch_enable drops
    do_reset(1'b1, 1'b1, 1'b0, 2);
    tick();
    check("t3_req", 64'(imem_req), 64'(1));
    for (int i = 0; i < 5; i++) begin
      tick();
      check("t3_hold_req", 64'(imem_req), 64'(1));
      check("t3_hold_addr", 64'(imem_addr), 64'h0);
      if (i == 1) fetch_enable = 1'b0;
    end
    imem_gnt = 1'b1;
    tick();
    check("t3_addr_adv", 64'(imem_addr), 64'h8);
    check("t3_req_drop", 64'(imem_req), 64'(0));

    // 4: redirect with three requests in flight; stale responses are dropped
    do_reset(1'b1, 1'b1, 1'b1, 5);
    repeat (4) tick();
    check("t4_inflight", 64'(n_grants), 64'(3));
    redirect_valid = 1'b1;
    redirect_pc = 16'h0101;
    imem_gnt = 1'b0;
    tick();
    redirect_valid = 1'b0;
    imem_gnt = 1'b1;
    check("t4_req", 64'(imem_req), 64'(1));
    check("t4_addr", 64'(imem_addr), 64'h400);
    check("t4_flushed", 64'(instr_valid), 64'(0));
    check("t4_redir_cnt", 64'(redirect_count), 64'(1));
    seen = 1'b0;
    repeat (5) begin
      tick();
      if (instr_valid) seen = 1'b1;
    end
    check("t4_no_stale_out", 64'(seen), 64'(0));
    tick();
    check("t4_valid", 64'(instr_valid), 64'(1));
    check("t4_pc", 64'(bundle_pc), 64'h100);
    check("t4_data", instruction_bundle, exp_data(16'h100));

    // 5: redirect coinciding with a handshake and an incoming response
    do_reset(1'b1, 1'b1, 1'b1, 2);
    repeat (7) tick();
    check("t5_pre_issued", 64'(bundles_issued), 64'(3));
    check("t5_pre_pc", 64'(bundle_pc), 64'h6);
    redirect_valid = 1'b1;
    redirect_pc = 16'h0200;
    tick();
    redirect_valid = 1'b0;
    check("t5_issued", 64'(bundles_issued), 64'(4));
    check("t5_flushed", 64'(instr_valid), 64'(0));
    check("t5_redir_cnt", 64'(redirect_count), 64'(1));
    check("t5_addr", 64'(imem_addr), 64'h800);
    tick();
    check("t5_stale1", 64'(instr_valid), 64'(0));
    tick();
    check("t5_stale2", 64'(instr_valid), 64'(0));
    tick();
    check("t5_valid", 64'(instr_valid), 64'(1));
    check("t5_pc", 64'(bundle_pc), 64'h200);
    check("t5_data", instruction_bundle, exp_data(16'h200));

    // 6: fetch and head PCs wrap at the top of the PC space
    do_reset(1'b0, 1'b1, 1'b1, 2);
    tick();
    check("t6_idle", 64'(imem_req), 64'(0));
    fetch_enable = 1'b1;
    redirect_valid = 1'b1;
    redirect_pc = 16'hFFFF;
    tick();
    redirect_valid = 1'b0;
    check("t6_req", 64'(imem_req), 64'(1));
    check("t6_addr_top", 64'(imem_addr), 64'h3FFF8);
    tick();
    check("t6_addr_wrap", 64'(imem_addr), 64'h0);
    tick();
    check("t6_addr8", 64'(imem_addr), 64'h8);
    tick();
    check("t6_pc_top", 64'(bundle_pc), 64'hFFFE);
    check("t6_data_top", instruction_bundle, exp_data(16'hFFFE));
    tick();
    check("t6_pc_wrap", 64'(bundle_pc), 64'h0);
    check("t6_data_wrap", instruction_bundle, exp_data(16'h0));
    check("t6_redir_cnt", 64'(redirect_count), 64'(1));

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
